main_memory_responder: RTL and testbench

- Responder end of the cache-to-main-memory request/ready protocol. It accepts single-word read and write requests from the last-level cache FSM and services them from an internal word array after a fixed access latency.
- Completion is signalled by a one-cycle main_memory_ready pulse.
- It is the backing store below L3 in the multi-layer cache hierarchy. It also exposes busy, error and access-count status for the bench.

---
 rtl/main_memory_responder.sv | 147 ++++++++++++++
 tb/tb_main_memory_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Single-word main memory responder below L3: accepts one read or write request level,
// services it from an internal word array and pulses ready exactly ACCESS_LATENCY cycles later.
module main_memory_responder #(
  parameter int MAIN_MEMORY_DATA_WIDTH    = 32,
  parameter int MAIN_MEMORY_ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH                 = 256,
  parameter int ACCESS_LATENCY            = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 main_memory_read_request,
  input  logic                                 main_memory_write_request,
  input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] main_memory_address,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_write_data,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_read_data,
  output logic                                 main_memory_ready,
  output logic                                 main_memory_busy,
  output logic                                 main_memory_protocol_error,
  output logic [15:0]                          main_memory_read_count,
  output logic [15:0]                          main_memory_write_count
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (ACCESS_LATENCY > 2) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]                  lat_cnt;
  logic [IDX_W-1:0]                  idx_q;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] wdata_q;
  logic                              op_write_q;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic accept;
  logic commit;
  logic load_rd;
  logic done;

  // Upper address bits are deliberately dropped so addresses wrap modulo MEM_DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^main_memory_address[MAIN_MEMORY_ADDRESS_WIDTH-1:IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state        = state;
    accept            = 1'b0;
    commit            = 1'b0;
    load_rd           = 1'b0;
    done              = 1'b0;
    main_memory_ready = 1'b0;
    main_memory_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (main_memory_read_request || main_memory_write_request) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        main_memory_busy = 1'b1;
        if (lat_cnt == '0) begin
          next_state = RESPOND;
          commit     = op_write_q;
          load_rd    = !op_write_q;
        end
      end
      RESPOND: begin
        main_memory_busy  = 1'b1;
        main_memory_ready = 1'b1;
        done              = 1'b1;
        next_state        = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt                    <= '0;
      idx_q                      <= '0;
      wdata_q                    <= '0;
      op_write_q                 <= 1'b0;
      main_memory_read_data      <= '0;
      main_memory_protocol_error <= 1'b0;
      main_memory_read_count     <= '0;
      main_memory_write_count    <= '0;
    end else begin
      if (accept) begin
        idx_q      <= main_memory_address[IDX_W-1:0];
        wdata_q    <= main_memory_write_data;
        // Write wins a simultaneous request; the dropped read is flagged.
        op_write_q <= main_memory_write_request;
        lat_cnt    <= CNT_INIT;
        if (main_memory_read_request && main_memory_write_request) begin
          main_memory_protocol_error <= 1'b1;
        end
      end else if (state == BUSY && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if (load_rd) begin
        main_memory_read_data <= mem[idx_q];
      end

      if (done) begin
        if (op_write_q) begin
          if (main_memory_write_count != 16'hFFFF) begin
            main_memory_write_count <= main_memory_write_count + 16'd1;
          end
        end else begin
          if (main_memory_read_count != 16'hFFFF) begin
            main_memory_read_count <= main_memory_read_count + 16'd1;
          end
        end
      end
    end
  end

  // Write commits one cycle before its ready pulse, so a back-to-back read sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: vector table with read-data scoreboard, plus reset-abort and short-latency sequences.
module tb_main_memory_responder;

  logic        clk;
  logic        reset;
  logic        rd_req, wr_req;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, busy, perr;
  logic [15:0] rcount, wcount;

  logic        rd2, wr2;
  logic [31:0] addr2, wdata2;
  logic [31:0] rdata2;
  logic        ready2, busy2, perr2;
  logic [15:0] rcount2, wcount2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          exp_rc, exp_wc;
  logic        exp_err;

  main_memory_responder #(.ACCESS_LATENCY(4)) u_dut (
    .clk(clk), .reset(reset),
    .main_memory_read_request(rd_req), .main_memory_write_request(wr_req),
    .main_memory_address(address), .main_memory_write_data(wdata),
    .main_memory_read_data(rdata), .main_memory_ready(ready),
    .main_memory_busy(busy), .main_memory_protocol_error(perr),
    .main_memory_read_count(rcount), .main_memory_write_count(wcount)
  );

  main_memory_responder #(.ACCESS_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .main_memory_read_request(rd2), .main_memory_write_request(wr2),
    .main_memory_address(addr2), .main_memory_write_data(wdata2),
    .main_memory_read_data(rdata2), .main_memory_ready(ready2),
    .main_memory_busy(busy2), .main_memory_protocol_error(perr2),
    .main_memory_read_count(rcount2), .main_memory_write_count(wcount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request in the current cycle (cycle 0) and follow it to its ready pulse.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    bit seen;
    logic [31:0] exp_v;
    seen   = 0;
    rd_req = rd;
    wr_req = wr;
    address = a;
    wdata  = d;
    if (rd && !wr) exp_q.push_back(exp_rd);
    if (rd && wr) exp_err = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_ready", ready, 0);
        chk("read_count", rcount, exp_rc);
        chk("write_count", wcount, exp_wc);
      end else if (!ready) begin
        chk("busy_inflight", busy, 1);
      end
      if (ready) begin
        seen = 1;
        chk("latency", c, 4);
        chk("busy_respond", busy, 1);
        chk("protocol_error", perr, exp_err);
        if (!wr) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: ready with empty queue");
          end else begin
            exp_v = exp_q.pop_front();
            chk("read_data", rdata, exp_v);
            last_rd = exp_v;
          end
          exp_rc++;
        end else begin
          chk("read_data_hold", rdata, last_rd);
          exp_wc++;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      @(posedge clk);
      #1;
      if (seen) break;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout: no ready within 20 cycles for addr 0x%08h", a);
      rd_req = 1'b0;
      wr_req = 1'b0;
    end
  endtask

  initial begin
    int ready_hits;

    tbl[0] = '{1'b1, 1'b0, 32'h10,   32'h0,        32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h20,   32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h20,   32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'h105,  32'hA5A5A5A5, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h005,  32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b1, 32'h30,   32'h12345678, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h30,   32'h0,        32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 32'h1020, 32'h0,        32'hDEADBEEF};
    tbl[8] = '{1'b0, 1'b1, 32'h20,   32'h11112222, 32'h0};
    tbl[9] = '{1'b1, 1'b0, 32'hFF20, 32'h0,        32'h11112222};

    reset = 1'b1;
    rd_req = 0; wr_req = 0; address = 0; wdata = 0;
    rd2 = 0; wr2 = 0; addr2 = 0; wdata2 = 0;
    exp_rc = 0; exp_wc = 0; exp_err = 0; last_rd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", perr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rcount", rcount, 0);
    chk("rst_wcount", wcount, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Minimum latency instance: read 0x01 -> ready in cycle 2, busy in cycles 1-2.
    rd2 = 1'b1; addr2 = 32'h1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("l2_ready", ready2, (c == 2) ? 32'd1 : 32'd0);
      chk("l2_busy", busy2, (c == 1 || c == 2) ? 32'd1 : 32'd0);
      if (c == 2) begin
        chk("l2_rdata", rdata2, 0);
        rd2 = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("l2_rcount", rcount2, 1);
    @(posedge clk);
    #1;

    // Back-to-back table: each request issued in the cycle right after the previous ready.
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
    end
    @(negedge clk);
    chk("tbl_rcount", rcount, exp_rc);
    chk("tbl_wcount", wcount, exp_wc);
    chk("tbl_perr_sticky", perr, 1);
    @(posedge clk);
    #1;

    // Reset in cycle 2 of a write to 0x40 aborts it.
    ready_hits = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin wr_req = 1'b1; address = 32'h40; wdata = 32'h55; end
      if (c == 2) begin reset = 1'b1; wr_req = 1'b0; end
      if (c == 3) reset = 1'b0;
      @(negedge clk);
      if (ready) ready_hits++;
      if (c == 3) chk("abort_busy", busy, 0);
      @(posedge clk);
      #1;
    end
    chk("abort_no_ready", ready_hits, 0);
    exp_rc = 0; exp_wc = 0; exp_err = 0; last_rd = 32'h0;
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
    @(negedge clk);
    chk("abort_rcount", rcount, 2);
    chk("abort_wcount", wcount, 0);
    chk("abort_perr", perr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
